// File: rtl/control_fsm_pkg.sv
// Shared types and constants for the datapath control FSM:
// state encoding, opcode values and instruction field widths.
package ctrl_pkg;

  localparam int IR_W  = 9;
  localparam int OPC_W = 3;
  localparam int REG_W = 3;
  localparam int NREG  = 8;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [OPC_W-1:0] OP_MV   = 3'b000;
  localparam logic [OPC_W-1:0] OP_MVI  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OPC_W-1:0] OP_MVNZ = 3'b100;

endpackage

// File: rtl/control_fsm_dec3to8.sv
// One-hot register load decoder: drives exactly one bit of onehot for sel
// while en is high, all zeros otherwise.
module dec3to8
  import ctrl_pkg::*;
(
  input  logic [REG_W-1:0] sel,
  input  logic             en,
  output logic [NREG-1:0]  onehot
);

  // one-hot decode gated by the load enable
  always_comb begin
    onehot = 8'h00;
    if (en) begin
      onehot[sel] = 1'b1;
    end else begin
      onehot = 8'h00;
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Four-step (T0..T3) control FSM for a simple register/ALU datapath.
// Optional mvnz (opcode 100) is enabled by defining CTRL_MVNZ_EN.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [IR_W-1:0]   ir,
  input  logic              g_nz,
  output logic              ir_in,
  output logic [NREG-1:0]   rin,
  output logic [REG_W-1:0]  rout,
  output logic              din_en,
  output logic              gout,
  output logic              a_in,
  output logic              g_in,
  output logic              addsub,
  output logic              done
);

  state_t            state_r;
  state_t            state_next_s;
  logic              load_en_s;
  logic [OPC_W-1:0]  opcode_s;
  logic [REG_W-1:0]  xxx_s;
  logic [REG_W-1:0]  yyy_s;

  assign opcode_s = ir[8:6];
  assign xxx_s    = ir[5:3];
  assign yyy_s    = ir[2:0];

`ifndef CTRL_MVNZ_EN
  logic unused_g_nz_s;
  assign unused_g_nz_s = g_nz;
`endif

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= T0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state and output decode; reset forces every output low at once
  always_comb begin
    state_next_s = state_r;
    load_en_s    = 1'b0;
    ir_in        = 1'b0;
    rout         = 3'd0;
    din_en       = 1'b0;
    gout         = 1'b0;
    a_in         = 1'b0;
    g_in         = 1'b0;
    addsub       = 1'b0;
    done         = 1'b0;
    case (state_r)
      T0: begin
        if (run) begin
          din_en       = 1'b1;
          ir_in        = 1'b1;
          state_next_s = T1;
        end else begin
          state_next_s = T0;
        end
      end
      T1: begin
        state_next_s = T0;
        case (opcode_s)
          OP_MV: begin
            rout      = yyy_s;
            load_en_s = 1'b1;
            done      = 1'b1;
          end
          OP_MVI: begin
            din_en    = 1'b1;
            load_en_s = 1'b1;
            done      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout         = xxx_s;
            a_in         = 1'b1;
            state_next_s = T2;
          end
`ifdef CTRL_MVNZ_EN
          OP_MVNZ: begin
            done = 1'b1;
            if (g_nz) begin
              rout      = yyy_s;
              load_en_s = 1'b1;
            end else begin
              load_en_s = 1'b0;
            end
          end
`endif
          default: begin
            done = 1'b1;
          end
        endcase
      end
      T2: begin
        rout         = yyy_s;
        g_in         = 1'b1;
        addsub       = ir[6];
        state_next_s = T3;
      end
      T3: begin
        gout         = 1'b1;
        load_en_s    = 1'b1;
        done         = 1'b1;
        state_next_s = T0;
      end
      default: begin
        state_next_s = T0;
      end
    endcase
    // an aborted instruction must not leak any strobe while reset is low
    if (!rst_n) begin
      load_en_s = 1'b0;
      ir_in     = 1'b0;
      rout      = 3'd0;
      din_en    = 1'b0;
      gout      = 1'b0;
      a_in      = 1'b0;
      g_in      = 1'b0;
      addsub    = 1'b0;
      done      = 1'b0;
    end else begin
      load_en_s = load_en_s;
    end
  end

  dec3to8 u_dec (
    .sel    (xxx_s),
    .en     (load_en_s),
    .onehot (rin)
  );

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have a single clock domain, with synchronous, active-low reset.
REQ-002 SHALL declare ports in this order, clock and reset first:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- run  in  1  start request; sampled only in T0
- ir  in  9  instruction {III opcode, XXX dest, YYY src}, held stable from T1 onward
- g_nz  in  1  G register non-zero flag; used only when CTRL_MVNZ_EN is defined
- ir_in  out  1  IR load enable
- rin  out  8  one-hot register load enables r0..r7
- rout  out  3  bus-mux register select
- din_en  out  1  bus-mux selects din
- gout  out  1  bus-mux selects aluout
- a_in  out  1  A register load enable
- g_in  out  1  G register load enable
- addsub  out  1  ALU operation: 0 = add, 1 = sub
- done  out  1  instruction-complete pulse

Function
REQ-003 SHALL implement a registered state machine with states T0, T1, T2 and T3; all outputs SHALL be combinational from the state and ir.
REQ-004 SHALL drive every output to 0 in any state and cycle where this document does not assert it.
REQ-005 T0: if run=1, SHALL assert din_en=1 and ir_in=1, then go to T1; if run=0, SHALL hold in T0.
REQ-006 SHALL ignore run in T1, T2 and T3; there is no request queuing.
REQ-007 T1, mv (000): SHALL assert rout=YYY, rin[XXX]=1 and done=1, then go to T0.
REQ-008 T1, mvi (001): SHALL assert din_en=1, rin[XXX]=1 and done=1, then go to T0.
REQ-009 T1, add (010) or sub (011): SHALL assert rout=XXX and a_in=1, then go to T2.
REQ-010 T2: SHALL assert rout=YYY, g_in=1 and addsub=ir[6], then go to T3.
REQ-011 T3: SHALL assert gout=1, rin[XXX]=1 and done=1, then go to T0.
REQ-012 T1, undefined opcode: SHALL assert done=1 only, then go to T0.
REQ-013 SHALL never assert din_en and gout in the same cycle.
REQ-014 SHALL drive rout=0 whenever din_en or gout is 1.
REQ-015 Latency: mv, mvi and undefined opcodes SHALL take 2 cycles from the T0 fetch; add and sub SHALL take 4 cycles.
REQ-016 SHALL assert done for exactly one cycle per instruction.
REQ-017 A mv with XXX=YYY SHALL be legal and perform a normal single-register load.

Reset
REQ-018 With rst_n=0 at a rising edge, the state SHALL become T0, regardless of run or the current state.
REQ-019 While rst_n=0, all outputs SHALL be 0, including during reset applied mid-instruction.
REQ-020 After a mid-instruction reset, no rin, g_in or done pulse from the aborted instruction SHALL appear.

Configuration
REQ-021 Macro CTRL_MVNZ_EN:
- defined: opcode 100 is mvnz; in T1 SHALL act as mv when g_nz=1, and assert done=1 only when g_nz=0.
- undefined: opcode 100 SHALL be treated as undefined per REQ-012, and g_nz SHALL be ignored.

Structure
REQ-022 Package ctrl_pkg SHALL hold the state enum (T0..T3), the opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ) and the field-width constants.
REQ-023 A sub-module dec3to8 SHALL produce the one-hot rin from XXX, gated by a load enable.

Verification
REQ-024 Reset: rst_n=0 for 2 cycles with run=1 and ir=9'o201 -> all outputs 0; the first run after release gives ir_in=1.
REQ-025 mv r2,r5: ir=9'b000_010_101, run pulse -> T1 gives rout=5, rin=8'h04, done=1; the next cycle is T0 with all outputs 0.
REQ-026 mvi r7: ir=9'b001_111_000 -> T1 gives din_en=1, rin=8'h80, done=1, rout=0.
REQ-027 add r1,r3: ir=9'b010_001_011 gives:
- T1: rout=1, a_in=1
- T2: rout=3, g_in=1, addsub=0
- T3: gout=1, rin=8'h02, done=1
REQ-028 sub r4,r0: ir=9'b011_100_000 with rst_n=0 at the T2 edge -> next cycle T0 with outputs 0; rin=8'h10 is never asserted.
REQ-029 mvnz r0,r1: ir=9'b100_000_001:
- macro defined, g_nz=1: rout=1, rin=8'h01, done=1.
- macro defined, g_nz=0: done=1 only.
- macro undefined: done=1 only, irrespective of g_nz.
